// File: rtl/led_arb_pkg.sv
// ============================================================================
//  Module   : led_arb_pkg
//  Brief    : Shared types, defaults and helpers for the LED bank arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package led_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } led_arb_state_e;

    localparam int          LED_ARB_W_DEF        = 16;
    localparam logic [15:0] LED_ARB_IDLE_PAT_DEF = 16'h0000;

    // Tenure counter must be able to hold MAX_HOLD itself so it can saturate there.
    function automatic int led_arb_cnt_width(input int max_hold);
        return (max_hold < 1) ? 1 : $clog2(max_hold + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/led_rr_pick.sv
// ============================================================================
//  Module   : led_rr_pick
//  Brief    : Combinational round-robin picker: first eligible request at or
//             above rr_ptr, wrapping, with a mask to exclude the current owner.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module led_rr_pick
    import led_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IW    = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    rr_ptr,
    input  logic [N_REQ-1:0] exclude,
    output logic [N_REQ-1:0] winner,
    output logic [IW-1:0]    winner_idx,
    output logic             any_valid
);

    logic [N_REQ-1:0]   w_cand;
    logic [2*N_REQ-1:0] w_dbl;
    logic [N_REQ-1:0]   w_rot;
    logic [IW-1:0]      w_off;
    logic [IW:0]        w_sum;

    assign w_cand = req & ~exclude;
    // Rotating the doubled vector puts rr_ptr at bit 0, so the lowest set bit wins.
    assign w_dbl  = {w_cand, w_cand} >> rr_ptr;
    assign w_rot  = w_dbl[N_REQ-1:0];

    always_comb begin
        w_off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = IW'(i);
            end
        end
    end

    assign w_sum      = {1'b0, rr_ptr} + {1'b0, w_off};
    assign winner_idx = (w_sum >= (IW+1)'(N_REQ)) ? IW'(w_sum - (IW+1)'(N_REQ)) : w_sum[IW-1:0];
    assign any_valid  = |w_cand;
    assign winner     = any_valid ? (N_REQ'(1) << winner_idx) : '0;

endmodule

`default_nettype wire

// File: rtl/led_arbiter.sv
// ============================================================================
//  Module   : led_arbiter
//  Brief    : Round-robin owner of the shared ledr bank with minimum tenure and
//             registered output mux. Define LED_ARB_PREEMPT_EN to let a waiting
//             requester preempt an owner after MAX_HOLD cycles.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module led_arbiter
    import led_arb_pkg::*;
#(
    parameter int           N_REQ    = 2,
    parameter int           W        = LED_ARB_W_DEF,
    parameter int           MIN_HOLD = 4,
    parameter int           MAX_HOLD = 64,
    parameter logic [W-1:0] IDLE_PAT = W'(LED_ARB_IDLE_PAT_DEF)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*W-1:0]         led_in,
    output logic [N_REQ-1:0]           grant,
    output logic [$clog2(N_REQ)-1:0]   owner_id,
    output logic                       busy,
    output logic [W-1:0]               ledr
);

    localparam int              c_IW      = $clog2(N_REQ);
    localparam int              c_HW      = led_arb_cnt_width(MAX_HOLD);
    localparam logic [0:0]      c_ST_IDLE = IDLE;
    localparam logic [0:0]      c_ST_OWN  = OWN;
    localparam logic [c_HW-1:0] c_MIN_M1  = c_HW'(MIN_HOLD - 1);
    localparam logic [c_HW-1:0] c_MAX     = c_HW'(MAX_HOLD);

    logic [0:0]       r_state;
    logic [N_REQ-1:0] r_grant;
    logic [c_IW-1:0]  r_owner;
    logic [c_IW-1:0]  r_rr_ptr;
    logic [c_HW-1:0]  r_hold;
    logic [W-1:0]     r_ledr;

    logic [N_REQ-1:0] w_excl;
    logic [N_REQ-1:0] w_win;
    logic [c_IW-1:0]  w_win_idx;
    logic             w_any;
    logic             w_owner_req;
    logic             w_release;
    logic             w_preempt;
    logic [c_IW-1:0]  w_ptr_next;
    logic [W-1:0]     w_owner_led;

    // While owning, the current owner is masked so a handoff always goes elsewhere.
    assign w_excl = (r_state == c_ST_OWN) ? r_grant : '0;

    led_rr_pick #(
        .N_REQ (N_REQ),
        .IW    (c_IW)
    ) u_pick (
        .req        (req),
        .rr_ptr     (r_rr_ptr),
        .exclude    (w_excl),
        .winner     (w_win),
        .winner_idx (w_win_idx),
        .any_valid  (w_any)
    );

    assign w_owner_req = |(req & r_grant);
    assign w_release   = !w_owner_req && (r_hold >= c_MIN_M1);
    assign w_ptr_next  = (w_win_idx == c_IW'(N_REQ - 1)) ? '0 : w_win_idx + c_IW'(1);

`ifdef LED_ARB_PREEMPT_EN
    assign w_preempt = w_owner_req && w_any && (r_hold == c_HW'(MAX_HOLD - 1));
`else
    assign w_preempt = 1'b0;
`endif

    always_comb begin
        w_owner_led = IDLE_PAT;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_owner == c_IW'(i)) begin
                w_owner_led = led_in[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_grant  <= '0;
            r_owner  <= '0;
            r_rr_ptr <= '0;
            r_hold   <= '0;
            r_ledr   <= IDLE_PAT;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_ledr <= IDLE_PAT;
                    if (w_any) begin
                        r_state  <= c_ST_OWN;
                        r_grant  <= w_win;
                        r_owner  <= w_win_idx;
                        r_rr_ptr <= w_ptr_next;
                        r_hold   <= '0;
                    end
                end
                default: begin
                    r_ledr <= w_owner_led;
                    if (w_release || w_preempt) begin
                        r_hold <= '0;
                        if (w_any) begin
                            r_grant  <= w_win;
                            r_owner  <= w_win_idx;
                            r_rr_ptr <= w_ptr_next;
                        end else begin
                            r_state <= c_ST_IDLE;
                            r_grant <= '0;
                        end
                    end else if (r_hold != c_MAX) begin
                        r_hold <= r_hold + c_HW'(1);
                    end
                end
            endcase
        end
    end

    assign grant    = r_grant;
    assign owner_id = r_owner;
    assign busy     = (r_state == c_ST_OWN);
    assign ledr     = r_ledr;

endmodule

`default_nettype wire

// File: tb/tb_led_arbiter.sv
// ============================================================================
//  Module   : tb_led_arbiter
//  Brief    : Scoreboard bench: stimulus queues expected grant/ledr changes,
//             a negedge monitor pops them as the DUT outputs change.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_led_arbiter;

    typedef struct {
        logic [15:0] val;
        logic [1:0]  owner;
        logic        busy;
        int          cyc;
    } ev_t;

    logic        clk;
    logic        rst;
    logic [1:0]  req_a;
    logic [31:0] led_a;
    logic [1:0]  grant_a;
    logic [0:0]  owner_a;
    logic        busy_a;
    logic [15:0] ledr_a;
    logic [3:0]  req_b;
    logic [63:0] led_b;
    logic [3:0]  grant_b;
    logic [1:0]  owner_b;
    logic        busy_b;
    logic [15:0] ledr_b;

    int  cyc;
    int  n_chk;
    int  n_pass;
    ev_t q_ga[$];
    ev_t q_la[$];
    ev_t q_gb[$];

    led_arbiter #(.N_REQ(2), .W(16), .MIN_HOLD(4), .MAX_HOLD(8), .IDLE_PAT(16'h0000)) dut_a (
        .clk(clk), .rst(rst), .req(req_a), .led_in(led_a),
        .grant(grant_a), .owner_id(owner_a), .busy(busy_a), .ledr(ledr_a)
    );

    led_arbiter #(.N_REQ(4), .W(16), .MIN_HOLD(4), .MAX_HOLD(64), .IDLE_PAT(16'h0000)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .led_in(led_b),
        .grant(grant_b), .owner_id(owner_b), .busy(busy_b), .ledr(ledr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_ga(input logic [15:0] g, input logic [1:0] o, input logic b, input int d);
        ev_t e;
        e.val = g; e.owner = o; e.busy = b; e.cyc = cyc + d;
        q_ga.push_back(e);
    endtask

    task automatic exp_la(input logic [15:0] v, input int d);
        ev_t e;
        e.val = v; e.owner = 2'd0; e.busy = 1'b0; e.cyc = cyc + d;
        q_la.push_back(e);
    endtask

    task automatic exp_gb(input logic [15:0] g, input logic [1:0] o, input logic b, input int d);
        ev_t e;
        e.val = g; e.owner = o; e.busy = b; e.cyc = cyc + d;
        q_gb.push_back(e);
    endtask

    // Monitor: every change of a watched output consumes one expected event.
    initial begin : monitor
        logic [1:0]  pa_g;
        logic [15:0] pa_l;
        logic [3:0]  pb_g;
        ev_t         e;
        pa_g = '0; pa_l = '0; pb_g = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pa_g = grant_a; pa_l = ledr_a; pb_g = grant_b;
            end else begin
                if (grant_a !== pa_g) begin
                    pa_g = grant_a;
                    if (q_ga.size() == 0) chk("grant_a_unexpected", 32'(grant_a), 32'hFFFF_FFFF);
                    else begin
                        e = q_ga.pop_front();
                        chk("grant_a", 32'(grant_a), 32'(e.val));
                        chk("owner_a", 32'(owner_a), 32'(e.owner));
                        chk("busy_a", 32'(busy_a), 32'(e.busy));
                        chk("grant_a_cycle", 32'(cyc), 32'(e.cyc));
                    end
                end
                if (ledr_a !== pa_l) begin
                    pa_l = ledr_a;
                    if (q_la.size() == 0) chk("ledr_a_unexpected", 32'(ledr_a), 32'hFFFF_FFFF);
                    else begin
                        e = q_la.pop_front();
                        chk("ledr_a", 32'(ledr_a), 32'(e.val));
                        chk("ledr_a_cycle", 32'(cyc), 32'(e.cyc));
                    end
                end
                if (grant_b !== pb_g) begin
                    pb_g = grant_b;
                    if (q_gb.size() == 0) chk("grant_b_unexpected", 32'(grant_b), 32'hFFFF_FFFF);
                    else begin
                        e = q_gb.pop_front();
                        chk("grant_b", 32'(grant_b), 32'(e.val));
                        chk("owner_b", 32'(owner_b), 32'(e.owner));
                        chk("busy_b", 32'(busy_b), 32'(e.busy));
                        chk("grant_b_cycle", 32'(cyc), 32'(e.cyc));
                    end
                end
            end
        end
    end

    initial begin : stim
        n_chk = 0; n_pass = 0;
        rst   = 1'b1;
        req_a = '0;
        req_b = '0;
        led_a = {16'h5A5A, 16'hA5A5};
        led_b = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        tick(3);
        chk("rst_grant_a", 32'(grant_a), 32'h0);
        chk("rst_busy_a",  32'(busy_a),  32'h0);
        chk("rst_owner_a", 32'(owner_a), 32'h0);
        chk("rst_ledr_a",  32'(ledr_a),  32'h0);
        chk("rst_grant_b", 32'(grant_b), 32'h0);
        rst = 1'b0;
        tick(1);

        // Single requester: grant next edge, pattern one edge later, release to idle.
        req_a = 2'b01; exp_ga(16'h1, 2'd0, 1'b1, 1); exp_la(16'hA5A5, 2);
        tick(10);
        req_a = 2'b00; exp_ga(16'h0, 2'd0, 1'b0, 1); exp_la(16'h0000, 2);
        tick(4);

        // Reset in the middle of requester 1's tenure acts before the next edge.
        req_a = 2'b10; exp_ga(16'h2, 2'd1, 1'b1, 1); exp_la(16'h5A5A, 2);
        tick(4);
        #2 rst = 1'b1; req_a = 2'b00;
        #1;
        chk("async_rst_grant", 32'(grant_a), 32'h0);
        chk("async_rst_busy",  32'(busy_a),  32'h0);
        chk("async_rst_ledr",  32'(ledr_a),  32'h0);
        chk("async_rst_owner", 32'(owner_a), 32'h0);
        tick(1);
        rst = 1'b0;
        tick(1);

        // Simultaneous requests after reset: 0 first, then direct handoff to 1.
        req_a = 2'b11; exp_ga(16'h1, 2'd0, 1'b1, 1); exp_la(16'hA5A5, 2);
        tick(5);
        req_a = 2'b10; exp_ga(16'h2, 2'd1, 1'b1, 1); exp_la(16'h5A5A, 2);
        tick(5);
        req_a = 2'b00; exp_ga(16'h0, 2'd1, 1'b0, 1); exp_la(16'h0000, 2);
        tick(4);

        // Early drop: grant kept for MIN_HOLD cycles; ledr tracks a live pattern change.
        req_a = 2'b01; exp_ga(16'h1, 2'd0, 1'b1, 1); exp_la(16'hA5A5, 2);
        tick(1);
        req_a = 2'b00;
        tick(1);
        led_a[15:0] = 16'h1234; exp_la(16'h1234, 1);
        exp_ga(16'h0, 2'd0, 1'b0, 3); exp_la(16'h0000, 4);
        tick(6);
        led_a[15:0] = 16'hA5A5;
        tick(2);

        // Preemption window: owner 0 keeps requesting, requester 1 arrives in tenure cycle 2.
        req_a = 2'b01; exp_ga(16'h1, 2'd0, 1'b1, 1); exp_la(16'hA5A5, 2);
        tick(2);
        req_a = 2'b11;
`ifdef LED_ARB_PREEMPT_EN
        exp_ga(16'h2, 2'd1, 1'b1, 7);  exp_la(16'h5A5A, 8);
        exp_ga(16'h1, 2'd0, 1'b1, 15); exp_la(16'hA5A5, 16);
`endif
        tick(10);
`ifdef LED_ARB_PREEMPT_EN
        chk("preempt_grant", 32'(grant_a), 32'h2);
`else
        chk("no_preempt_grant", 32'(grant_a), 32'h1);
`endif
        tick(8);
        req_a = 2'b00; exp_ga(16'h0, 2'd0, 1'b0, 1); exp_la(16'h0000, 2);
        tick(4);

        // Fairness with four requesters: each owner briefly drops req after MIN_HOLD.
        req_b = 4'b1111; exp_gb(16'h1, 2'd0, 1'b1, 1);
        tick(4);
        for (int k = 0; k < 4; k++) begin
            req_b[k] = 1'b0;
            exp_gb(16'(4'b0001 << ((k + 1) % 4)), 2'((k + 1) % 4), 1'b1, 1);
            tick(1);
            req_b = 4'b1111;
            tick(3);
        end
        req_b = 4'b0000; exp_gb(16'h0, 2'd0, 1'b0, 1);
        tick(5);

        chk("grant_a_events_left", 32'(q_ga.size()), 32'h0);
        chk("ledr_a_events_left",  32'(q_la.size()), 32'h0);
        chk("grant_b_events_left", 32'(q_gb.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
